// File: rtl/duck_motion_if.sv
// Duck motion controller bus: game inputs toward the controller and
// sprite/status outputs toward the renderer and the round controller.
interface duck_motion_if;
    logic        game_enable;
    logic        target_killed;
    logic [1:0]  speed_level;
    logic [9:0]  lfsr_number;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        duck_direction;
    logic        duck_hit;
    logic        duck_done;
    logic        escaped;

    modport master (
        output game_enable, target_killed, speed_level, lfsr_number,
        input  xpos, ypos, duck_direction, duck_hit, duck_done, escaped
    );

    modport slave (
        input  game_enable, target_killed, speed_level, lfsr_number,
        output xpos, ypos, duck_direction, duck_hit, duck_done, escaped
    );
endinterface

// File: rtl/duck_motion_ctl.sv
// duck_motion_ctl: one duck's life cycle -- spawn, diagonal flight with
// wall/ground/sky bounces, hit freeze and fall, timed escape off the top.
// Optional feature macro DUCK_RANDOM_BOUNCE_EN: vertical bounces pick a new
// horizontal direction from lfsr_number[0] (still forced away from a wall).
//
// state    | meaning
// ---------+----------------------------------------------
// IDLE     | no duck, position held
// SPAWN    | load spawn position, latch speed, clear timer
// FLY_UR   | flying up-right
// FLY_UL   | flying up-left
// FLY_DR   | flying down-right
// FLY_DL   | flying down-left
// HIT      | frozen after a kill for HIT_HOLD clocks
// FALL     | dropping to the ground line
// ESCAPE   | rising off the top of the screen
// DONE     | one-clock end-of-life pulse
module duck_motion_ctl #(
    parameter int X_MAX         = 1024,
    parameter int GROUND        = 620,
    parameter int DUCK_W        = 96,
    parameter int DUCK_H        = 32,
    parameter int FRAC          = 24,
    parameter int X_STEP        = 100,
    parameter int Y_STEP        = 95,
    parameter int FALL_STEP     = 400,
    parameter int HIT_HOLD      = 1 << 22,
    parameter int ESCAPE_CYCLES = 1 << 28
) (
    input logic         clk,
    input logic         rst,
    duck_motion_if.slave bus
);
    localparam int W    = FRAC + 12;
    localparam int X_HI = X_MAX - DUCK_W;
    localparam int Y_HI = GROUND - DUCK_H;
    localparam int TW   = (ESCAPE_CYCLES > 2) ? $clog2(ESCAPE_CYCLES) : 1;
    localparam int HW   = (HIT_HOLD > 2) ? $clog2(HIT_HOLD) : 1;
    localparam logic [W-1:0] X_HI_F  = W'(X_HI) << FRAC;
    localparam logic [W-1:0] Y_HI_F  = W'(Y_HI) << FRAC;
    localparam logic [W-1:0] X_MID_F = W'(X_MAX / 2) << FRAC;

    typedef enum logic [3:0] {
        S_IDLE, S_SPAWN, S_FLY_UR, S_FLY_UL, S_FLY_DR, S_FLY_DL,
        S_HIT, S_FALL, S_ESCAPE, S_DONE
    } state_t;

    state_t        state, state_n;
    logic [W-1:0]  px, py, px_n, py_n;
    logic [1:0]    spd, spd_n;
    logic [TW-1:0] timer, timer_n;
    logic [HW-1:0] hold_cnt, hold_n;
    logic [11:0]   xpos_q, ypos_q;
    logic          dir_q, hit_q, done_q, esc_q;
    logic          dir_n, esc_n;
    logic          left, up, new_left, new_up;
    logic [2:0]    spd_mult;
    logic [W-1:0]  step_x, step_y;
    logic [11:0]   x_int, y_int, lfsr_ext, spawn_x;
    logic          x_at_hi, x_at_lo, y_at_hi, y_at_lo;

    function automatic logic [W-1:0] sat_add(input logic [W-1:0] a,
                                             input logic [W-1:0] b,
                                             input logic [W-1:0] hi);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= {1'b0, hi}) ? hi : s[W-1:0];
    endfunction

    // Lower bound of both axes is zero, so subtraction clamps there.
    function automatic logic [W-1:0] sat_sub(input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        return (a <= b) ? '0 : a - b;
    endfunction

    assign spd_mult = {1'b0, spd} + 3'd1;
    assign step_x   = W'(X_STEP) * W'(spd_mult);
    assign step_y   = W'(Y_STEP) * W'(spd_mult);
    assign x_int    = px[W-1:FRAC];
    assign y_int    = py[W-1:FRAC];
    assign x_at_hi  = x_int >= 12'(X_HI);
    assign x_at_lo  = x_int == 12'd0;
    assign y_at_hi  = y_int >= 12'(Y_HI);
    assign y_at_lo  = y_int == 12'd0;
    assign lfsr_ext = {2'b00, bus.lfsr_number};
    assign spawn_x  = (lfsr_ext >= 12'(X_HI)) ? lfsr_ext - 12'(DUCK_W) : lfsr_ext;
    assign left     = (state == S_FLY_UL) || (state == S_FLY_DL);
    assign up       = (state == S_FLY_UR) || (state == S_FLY_UL);

    // Next-state, position and timer computation.
    always_comb begin
        state_n  = state;
        px_n     = px;
        py_n     = py;
        spd_n    = spd;
        timer_n  = timer;
        hold_n   = hold_cnt;
        esc_n    = esc_q;
        dir_n    = dir_q;
        new_left = left;
        new_up   = up;
        if (!bus.game_enable && state != S_DONE) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  state_n = S_SPAWN;
                S_SPAWN: begin
                    px_n    = {spawn_x, {FRAC{1'b0}}};
                    py_n    = Y_HI_F;
                    spd_n   = bus.speed_level;
                    timer_n = '0;
                    esc_n   = 1'b0;
                    state_n = (spawn_x >= 12'(X_MAX / 2)) ? S_FLY_UL : S_FLY_UR;
                end
                S_FLY_UR, S_FLY_UL, S_FLY_DR, S_FLY_DL: begin
                    if (bus.target_killed) begin
                        state_n = S_HIT;
                        hold_n  = HW'(HIT_HOLD - 1);
                    end else begin
                        px_n    = left ? sat_sub(px, step_x) : sat_add(px, step_x, X_HI_F);
                        py_n    = up ? sat_sub(py, step_y) : sat_add(py, step_y, Y_HI_F);
                        timer_n = timer + 1'b1;
                        if ((!left && x_at_hi) || (left && x_at_lo)) begin
                            new_left = !left;
                        end else if ((up && y_at_lo) || (!up && y_at_hi)) begin
                            new_up = !up;
`ifdef DUCK_RANDOM_BOUNCE_EN
                            new_left = bus.lfsr_number[0];
                            if (x_at_hi)
                                new_left = 1'b1;
                            else if (x_at_lo)
                                new_left = 1'b0;
`endif
                        end
                        if (timer == TW'(ESCAPE_CYCLES - 1))
                            state_n = S_ESCAPE;
                        else
                            case ({new_up, new_left})
                                2'b11:   state_n = S_FLY_UL;
                                2'b10:   state_n = S_FLY_UR;
                                2'b01:   state_n = S_FLY_DL;
                                default: state_n = S_FLY_DR;
                            endcase
                    end
                end
                S_HIT: begin
                    if (hold_cnt == '0)
                        state_n = S_FALL;
                    else
                        hold_n = hold_cnt - 1'b1;
                end
                S_FALL: begin
                    if (y_at_hi) begin
                        state_n = S_DONE;
                        esc_n   = 1'b0;
                    end else begin
                        py_n = sat_add(py, W'(FALL_STEP), Y_HI_F);
                    end
                end
                S_ESCAPE: begin
                    if (y_at_lo) begin
                        state_n = S_DONE;
                        esc_n   = 1'b1;
                    end else begin
                        py_n = sat_sub(py, step_y);
                    end
                end
                S_DONE:  state_n = S_IDLE;
                default: state_n = S_IDLE;
            endcase
        end
        // HIT/FALL/ESCAPE keep whatever facing the duck had in flight.
        if (state_n == S_FLY_UL || state_n == S_FLY_DL)
            dir_n = 1'b1;
        else if (state_n == S_FLY_UR || state_n == S_FLY_DR)
            dir_n = 1'b0;
    end

    // State, accumulators and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            px       <= X_MID_F;
            py       <= '0;
            spd      <= '0;
            timer    <= '0;
            hold_cnt <= '0;
            xpos_q   <= '0;
            ypos_q   <= '0;
            dir_q    <= 1'b0;
            hit_q    <= 1'b0;
            done_q   <= 1'b0;
            esc_q    <= 1'b0;
        end else begin
            state    <= state_n;
            px       <= px_n;
            py       <= py_n;
            spd      <= spd_n;
            timer    <= timer_n;
            hold_cnt <= hold_n;
            xpos_q   <= px[W-1:FRAC];
            ypos_q   <= py[W-1:FRAC];
            dir_q    <= dir_n;
            hit_q    <= (state_n == S_HIT) || (state_n == S_FALL);
            done_q   <= (state_n == S_DONE);
            esc_q    <= esc_n;
        end
    end

    assign bus.xpos           = xpos_q;
    assign bus.ypos           = ypos_q;
    assign bus.duck_direction = dir_q;
    assign bus.duck_hit       = hit_q;
    assign bus.duck_done      = done_q;
    assign bus.escaped        = esc_q;
endmodule
